// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronised input, mid-bit sampling, framing error and line-break hold-off.
// Optional parity check is enabled by defining UART_RX_PARITY_EN (adds parity_err port and PARITY_ODD parameter).
module uart_rx_os #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d,
  output logic [DATA_BITS-1:0] dout,
  output logic                 done,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  , output logic               parity_err
`endif
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIDX_W-1:0]      bidx_q, bidx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   dout_q, dout_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;
  logic                   ds;
`ifdef UART_RX_PARITY_EN
  logic                   pbad_q, pbad_d;
  logic                   perr_q, perr_d;
`endif

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], d};
    ds      = sync_q[SYNC_STAGES-1];
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!ds) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          bidx_d  = '0;
          state_d = ds ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          // Right shift: the first bit received ends up in bit 0.
          shreg_d = {ds, shreg_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          if (bidx_q == BIDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bidx_d = bidx_q + BIDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          pbad_d  = ((^shreg_q) ^ ds) != PARITY_ODD;
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          dout_d  = shreg_q;
          ferr_d  = ~ds;
          done_d  = 1'b1;
          cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
          perr_d  = pbad_q;
`endif
          // A low stop bit may be a break; wait for the line to go idle before re-arming.
          state_d = ds ? S_IDLE : S_BREAK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (ds) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= pbad_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign dout      = dout_q;
  assign done      = done_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at CLKS_PER_BIT=4, DATA_BITS=8, SYNC_STAGES=2.
// With UART_RX_PARITY_EN defined, every frame carries an even parity bit and a parity section runs.
module tb_uart_rx_os;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d   = 1'b1;
  logic [7:0] dout;
  logic       done, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int tests = 0;
  int fails = 0;

  uart_rx_os #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .d(d), .dout(dout), .done(done),
    .frame_err(frame_err), .busy(busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Done-pulse log, sampled on the falling edge.
  int         cyc  = 0;
  int         dcnt = 0;
  logic [7:0] log_dout [0:31];
  logic       log_fe   [0:31];
  logic       log_pe   [0:31];
  int         log_t    [0:31];
  logic       prev_done = 1'b0;
  logic       dbl = 1'b0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_done <= done;
    if (done && prev_done) dbl <= 1'b1;
    if (done) begin
      log_dout[dcnt % 32] <= dout;
      log_fe[dcnt % 32]   <= frame_err;
`ifdef UART_RX_PARITY_EN
      log_pe[dcnt % 32]   <= parity_err;
`else
      log_pe[dcnt % 32]   <= 1'b0;
`endif
      log_t[dcnt % 32]    <= cyc;
      dcnt                <= dcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    d = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic frame_raw(input logic [7:0] v, input logic pbit, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(v[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(pbit);
`else
    if (pbit) d = 1'b1;
`endif
    bit_out(stop);
  endtask

  task automatic frame(input logic [7:0] v, input logic stop);
    frame_raw(v, ^v, stop);
  endtask

  task automatic idle(input int n);
    d = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int base;

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    idle(4);

    // Nominal 0xAB
    frame(8'hAB, 1'b1);
    idle(6);
    check("nom_cnt", 32'(dcnt), 32'd1);
    check("nom_dout", 32'(log_dout[0]), 32'hAB);
    check("nom_ferr", 32'(log_fe[0]), 32'h0);
    check("nom_busy", 32'(busy), 32'h0);

    // One-clock glitch
    d = 1'b0;
    @(negedge clk);
    idle(8);
    check("gl_cnt", 32'(dcnt), 32'd1);
    check("gl_busy", 32'(busy), 32'h0);
    check("gl_dout", 32'(dout), 32'hAB);

    // Framing error then line break
    frame(8'h3C, 1'b0);
    d = 1'b0;
    repeat (20) @(negedge clk);
    check("fe_cnt", 32'(dcnt), 32'd2);
    check("fe_dout", 32'(log_dout[1]), 32'h3C);
    check("fe_ferr", 32'(log_fe[1]), 32'h1);
    check("fe_busy_brk", 32'(busy), 32'h1);
    idle(6);
    check("fe_busy_idle", 32'(busy), 32'h0);
    check("fe_no_retrig", 32'(dcnt), 32'd2);
    frame(8'h55, 1'b1);
    idle(6);
    check("rec_cnt", 32'(dcnt), 32'd3);
    check("rec_dout", 32'(log_dout[2]), 32'h55);
    check("rec_ferr", 32'(log_fe[2]), 32'h0);

    // Back-to-back frames
    frame(8'h01, 1'b1);
    frame(8'hFF, 1'b1);
    idle(6);
    check("b2b_cnt", 32'(dcnt), 32'd5);
    check("b2b_d0", 32'(log_dout[3]), 32'h01);
    check("b2b_d1", 32'(log_dout[4]), 32'hFF);
`ifdef UART_RX_PARITY_EN
    check("b2b_gap", 32'(log_t[4] - log_t[3]), 32'(11 * CPB));
`else
    check("b2b_gap", 32'(log_t[4] - log_t[3]), 32'(10 * CPB));
`endif

    // Reset in the middle of data bit 4 of 0xA5
    base = dcnt;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(logic'(8'hA5 >> i));
    d = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_dout", 32'(dout), 32'h0);
    check("mrst_done", 32'(done), 32'h0);
    check("mrst_ferr", 32'(frame_err), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    d = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(8);
    check("mrst_nodone", 32'(dcnt), 32'(base));
    frame(8'hA5, 1'b1);
    idle(6);
    check("a5_cnt", 32'(dcnt), 32'(base + 1));
    check("a5_dout", 32'(log_dout[base]), 32'hA5);
    check("a5_ferr", 32'(log_fe[base]), 32'h0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so parity bit 1 is correct
    frame_raw(8'h07, 1'b1, 1'b1);
    idle(6);
    check("par_ok_cnt", 32'(dcnt), 32'(base + 2));
    check("par_ok_pe", 32'(log_pe[base + 1]), 32'h0);
    frame_raw(8'h07, 1'b0, 1'b1);
    idle(6);
    check("par_bad_cnt", 32'(dcnt), 32'(base + 3));
    check("par_bad_pe", 32'(log_pe[base + 2]), 32'h1);
    check("par_bad_dout", 32'(log_dout[base + 2]), 32'h07);
    check("par_bad_ferr", 32'(log_fe[base + 2]), 32'h0);
`endif

    check("no_double_done", 32'(dbl), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised successor to the team's one-bit-per-clock UART FSM receiver.
- Oversamples the serial line at CLKS_PER_BIT clocks per bit and synchronises the asynchronous input.
- Samples each bit at mid-bit and supports configurable data width.
- Reports framing errors and holds off after a line break; sits between the pad and the byte-level protocol logic.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
CLKS_PER_BIT, 16, clocks per bit period (even, >=4)
SYNC_STAGES, 2, synchroniser flops on d (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
d  input  1  serial line, idle high, asynchronous to clk
dout  output  DATA_BITS  last received word, held until next done
done  output  1  one-cycle pulse: frame complete, dout/frame_err valid
frame_err  output  1  stop bit sampled low; valid with done, held until next done
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async):
  - dout=0, done=0, frame_err=0, busy=0.
  - Synchroniser flops set to 1; state=IDLE; counters cleared.
  - Reset mid-frame aborts the frame; no done is produced.
- All FSM decisions use ds, the output of the SYNC_STAGES-deep synchroniser. This adds SYNC_STAGES cycles of fixed input latency.
- Counters:
  - cnt is a bit-timing counter, 0..CLKS_PER_BIT-1.
  - bidx is a bit index, 0..DATA_BITS-1.
  - Widths are $clog2-sized.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: when ds==0, go to START with cnt=0. Otherwise stay.
- START: cnt increments each clock. At cnt==CLKS_PER_BIT/2-1 (mid start bit):
  - ds==0: go to DATA, cnt=0, bidx=0.
  - ds==1: false start (glitch), go to IDLE; no done, no error.
- DATA:
  - At cnt==CLKS_PER_BIT-1 (one bit period after the previous sample point): shift ds into the MSB of the shift register, with a right shift so bit 0 arrives first. Set cnt=0.
  - If bidx==DATA_BITS-1, go to STOP; else bidx++.
- STOP: at cnt==CLKS_PER_BIT-1:
  - ds==1: dout<=shift register, frame_err<=0, done<=1 next cycle, go to IDLE.
  - ds==0: dout<=shift register, frame_err<=1, done<=1 next cycle, go to BREAK.
- BREAK: wait for ds==1, then go to IDLE. A held-low line never retriggers START.
- done:
  - Registered; high exactly one cycle per accepted frame, never two consecutive cycles.
  - A new start bit may be detected in the same cycle done is high (back-to-back frames supported).
- Latency: done rises SYNC_STAGES + 1 cycles after the mid-stop-bit clock edge on raw d.
- d changes during a bit other than at the sample point have no effect.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - Adds output parity_err (1 bit, reset 0, valid with done, held until next done).
  - Adds parameter PARITY_ODD (default 0 = even parity).
  - FSM gains state PARITY between DATA and STOP. It samples one bit at cnt==CLKS_PER_BIT-1.
  - parity_err=1 when the XOR of the data bits and the parity bit does not equal PARITY_ODD.
  - A parity error does not suppress done, and does not alter dout or frame_err.
- When undefined: no PARITY state, no parity_err port; frame is start + DATA_BITS + stop.

Test Plan:
- Nominal (CLKS_PER_BIT=4, DATA_BITS=8): rst low 2 cycles then high, d=1; send start, 0xAB LSB first (1,1,0,1,0,1,0,1), stop=1, 4 clocks each -> one done pulse, dout=8'hAB, frame_err=0, busy low after done.
- Glitch: d low for 1 clock then high (CLKS_PER_BIT=4) -> START aborts at mid-bit, no done, busy returns 0, dout unchanged.
- Framing error: send 0x3C with stop=0, hold d low 20 clocks, then high -> done with dout=8'h3C, frame_err=1; no second done while low; next valid frame 0x55 -> done, dout=8'h55, frame_err=0.
- Back-to-back: 0x01 then 0xFF with no idle gap -> two done pulses exactly 10*CLKS_PER_BIT cycles apart, dout 8'h01 then 8'hFF.
- Reset mid-frame: assert rst during DATA bit 4 -> outputs zero immediately (async); after release, a clean 0xA5 frame gives dout=8'hA5, done once.
- UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 -> parity_err=0; same data with parity bit 0 -> parity_err=1, done still pulses, dout=8'h07.
